// File: rtl/pi_limit_multich_if.sv
// Step handshake and channel data bus for the multichannel limited PI controller.
// The bench or host drives the master side; the controller is the slave.
interface pi_limit_multich_if #(
  parameter int N_CH = 4
);
  logic                rst_user;
  logic                sta;
  logic [32*N_CH-1:0]  x;
  logic [32*N_CH-1:0]  y;
  logic                done_sig;
  logic                busy;
  logic                overrun;

  modport master (
    output rst_user, sta, x,
    input  y, done_sig, busy, overrun
  );

  modport slave (
    input  rst_user, sta, x,
    output y, done_sig, busy, overrun
  );
endinterface

// File: rtl/pi_limit_multich.sv
// Time-multiplexed N_CH-channel PI controller with output clamp and integrator anti-windup.
// A single float add/mul pipeline is shared by all channels; one done_sig pulse ends each step.
module pi_limit_multich #(
  parameter int          N_CH        = 4,
  parameter logic [31:0] KP          = 32'h3F000000,
  parameter logic [31:0] A2          = 32'h3E800000,
  parameter logic [31:0] UPPER_LIMIT = 32'h3FC00000,
  parameter logic [31:0] DOWN_LIMIT  = 32'hBFC00000,
  parameter int          MODE        = 0,
  parameter int          MUL_LAT     = 5,
  parameter int          ADD_LAT     = 7
) (
  input  logic               clk,
  input  logic               rst,
  pi_limit_multich_if.slave  bus
);

  localparam int PIPE_LAT = MUL_LAT + 3*ADD_LAT + 2;
  localparam int CHW      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int P_LEN    = 2*ADD_LAT + MUL_LAT + 1;
  localparam int S3_IDX   = ADD_LAT + MUL_LAT - 1;
  localparam int S4_IDX   = 2*ADD_LAT + MUL_LAT - 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic           hold;
    logic [31:0]    integ;
    logic [31:0]    x;
  } sb_t;

  // Round-to-nearest-even multiply; subnormals flush to zero, overflow goes to infinity.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic              sgn;
    logic [47:0]       prod;
    logic [23:0]       m;
    logic              g;
    logic              s;
    logic [24:0]       mr;
    logic signed [9:0] e;
    logic [31:0]       r;
    sgn  = a[31] ^ b[31];
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod[47]) begin
      m = prod[47:24];
      g = prod[23];
      s = |prod[22:0];
      e = e + 10'sd1;
    end else begin
      m = prod[46:23];
      g = prod[22];
      s = |prod[21:0];
    end
    mr = {1'b0, m} + {24'd0, g & (s | m[0])};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 10'sd0 || !mr[23])
      r = {sgn, 31'd0};
    else if (e >= 10'sd255)
      r = {sgn, 8'hFF, 23'd0};
    else
      r = {sgn, e[7:0], mr[22:0]};
    return r;
  endfunction

  // Round-to-nearest-even add; exact cancellation yields +0.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       big;
    logic [31:0]       sml;
    logic [7:0]        eb;
    logic [7:0]        es;
    logic [23:0]       mb;
    logic [23:0]       ms;
    logic [49:0]       sh;
    logic [26:0]       xb;
    logic [26:0]       xs;
    logic [26:0]       n;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic              found;
    logic signed [9:0] e;
    logic [24:0]       mr;
    logic [31:0]       r;
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    eb = big[30:23];
    es = sml[30:23];
    mb = (eb == 8'd0) ? 24'd0 : {1'b1, big[22:0]};
    ms = (es == 8'd0) ? 24'd0 : {1'b1, sml[22:0]};
    sh = {ms, 26'd0} >> (eb - es);
    xb = {mb, 3'b000};
    xs = {sh[49:24], |sh[23:0]};
    if (big[31] == sml[31])
      sum = {1'b0, xb} + {1'b0, xs};
    else
      sum = {1'b0, xb} - {1'b0, xs};
    e = $signed({2'b00, eb});
    if (sum[27]) begin
      n = {sum[27:2], |sum[1:0]};
      e = e + 10'sd1;
    end else begin
      lz    = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found && sum[i]) begin
          lz    = 5'(26 - i);
          found = 1'b1;
        end
      end
      n = sum[26:0] << lz;
      e = e - $signed({5'd0, lz});
    end
    mr = {1'b0, n[26:3]} + {24'd0, n[2] & (n[1] | n[0] | n[3])};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (sum == 28'd0 || e <= 10'sd0 || !mr[23])
      r = 32'd0;
    else if (e >= 10'sd255)
      r = {big[31], 8'hFF, 23'd0};
    else
      r = {big[31], e[7:0], mr[22:0]};
    return r;
  endfunction

  // Total-order key: both zeros map to 0 so -0 == +0.
  function automatic logic signed [32:0] fkey(input logic [31:0] v);
    logic signed [32:0] mag;
    mag = (v[30:23] == 8'd0) ? 33'sd0 : $signed({2'b00, v[30:0]});
    return v[31] ? -mag : mag;
  endfunction

  function automatic logic fgt(input logic [31:0] a, input logic [31:0] b);
    return fkey(a) > fkey(b);
  endfunction

  function automatic logic [31:0] fclamp(input logic [31:0] v);
    logic [31:0] r;
    if (fgt(v, UPPER_LIMIT))
      r = UPPER_LIMIT;
    else if (fgt(DOWN_LIMIT, v))
      r = DOWN_LIMIT;
    else
      r = v;
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [CHW-1:0]      cnt_q, cnt_d;
  logic                iss_vld;
  logic                load_x;
  logic                overrun_q;
  logic [31:0]         xbuf_q  [N_CH];
  logic [31:0]         integ_q [N_CH];
  logic [31:0]         xprev_q [N_CH];
  logic [31:0]         ysh_q   [N_CH];
  logic [N_CH-1:0]     sat_hi_q, sat_lo_q;
  logic [32*N_CH-1:0]  y_q;
  logic [32*N_CH-1:0]  ypack_d;
  logic [PIPE_LAT-1:0] vld_q;

  sb_t                 iss_sb;
  sb_t                 sb_q   [PIPE_LAT];
  sb_t                 wb_sb;
  logic                wb_vld;
  logic [31:0]         a1_q   [ADD_LAT];
  logic [31:0]         m_q    [MUL_LAT];
  logic [31:0]         a2_q   [ADD_LAT];
  logic [31:0]         a3_q   [ADD_LAT];
  logic [31:0]         p_q    [P_LEN];
  logic [31:0]         ci_q   [ADD_LAT+2];
  logic [31:0]         y6_q;
  logic                hi6_q, lo6_q;

  assign wb_vld = vld_q[PIPE_LAT-1];
  assign wb_sb  = sb_q[PIPE_LAT-1];

  // Operand fetch for the channel being issued; hold is decided from last step's saturation.
  always_comb begin
    iss_sb.ch    = cnt_q;
    iss_sb.x     = xbuf_q[cnt_q];
    iss_sb.integ = integ_q[cnt_q];
    iss_sb.hold  = (MODE != 0) &&
                   ((sat_hi_q[cnt_q] && fgt(xbuf_q[cnt_q], 32'd0)) ||
                    (sat_lo_q[cnt_q] && fgt(32'd0, xbuf_q[cnt_q])));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iss_vld = 1'b0;
    load_x  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sta) begin
          state_d = ISSUE;
          cnt_d   = '0;
          load_x  = 1'b1;
        end
      end
      ISSUE: begin
        iss_vld = 1'b1;
        if (cnt_q == CHW'(N_CH - 1))
          state_d = DRAIN;
        else
          cnt_d = cnt_q + CHW'(1);
      end
      DRAIN: begin
        if (wb_vld && wb_sb.ch == CHW'(N_CH - 1))
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.rst_user) begin
      state_d = IDLE;
      iss_vld = 1'b0;
      load_x  = 1'b0;
    end
  end

  // Shadow outputs with the current write-back merged, so y updates on entry to DONE.
  always_comb begin
    ypack_d = '0;
    for (int k = 0; k < N_CH; k++)
      ypack_d[32*k +: 32] = (wb_vld && wb_sb.ch == CHW'(k)) ? y6_q : ysh_q[k];
  end

  // Stage 1: x+xprev adder; KP*x multiplies alongside and is delayed to stage 5.
  always_ff @(posedge clk) begin
    sb_q[0] <= iss_sb;
    for (int i = 1; i < PIPE_LAT; i++) sb_q[i] <= sb_q[i-1];
    a1_q[0] <= fadd(iss_sb.x, xprev_q[cnt_q]);
    for (int i = 1; i < ADD_LAT; i++) a1_q[i] <= a1_q[i-1];
    p_q[0] <= fmul(KP, iss_sb.x);
    for (int i = 1; i < P_LEN; i++) p_q[i] <= p_q[i-1];
    // Stage 2: scale by A2
    m_q[0] <= fmul(a1_q[ADD_LAT-1], A2);
    for (int i = 1; i < MUL_LAT; i++) m_q[i] <= m_q[i-1];
    // Stage 3: accumulate onto integ
    a2_q[0] <= fadd(m_q[MUL_LAT-1], sb_q[S3_IDX].integ);
    for (int i = 1; i < ADD_LAT; i++) a2_q[i] <= a2_q[i-1];
    // Stage 4: integrator clamp (or hold); ci is also delayed to write-back
    ci_q[0] <= sb_q[S4_IDX].hold ? sb_q[S4_IDX].integ : fclamp(a2_q[ADD_LAT-1]);
    for (int i = 1; i < ADD_LAT + 2; i++) ci_q[i] <= ci_q[i-1];
    // Stage 5: add proportional term
    a3_q[0] <= fadd(ci_q[0], p_q[P_LEN-1]);
    for (int i = 1; i < ADD_LAT; i++) a3_q[i] <= a3_q[i-1];
    // Stage 6: output clamp and saturation flags
    y6_q  <= fclamp(a3_q[ADD_LAT-1]);
    hi6_q <= fgt(a3_q[ADD_LAT-1], UPPER_LIMIT);
    lo6_q <= fgt(DOWN_LIMIT, a3_q[ADD_LAT-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      vld_q     <= '0;
      sat_hi_q  <= '0;
      sat_lo_q  <= '0;
      y_q       <= '0;
      for (int k = 0; k < N_CH; k++) begin
        xbuf_q[k]  <= 32'd0;
        integ_q[k] <= 32'd0;
        xprev_q[k] <= 32'd0;
        ysh_q[k]   <= 32'd0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= bus.sta && (state_q != IDLE);
      vld_q     <= bus.rst_user ? '0 : {vld_q[PIPE_LAT-2:0], iss_vld};
      if (load_x) begin
        for (int k = 0; k < N_CH; k++) xbuf_q[k] <= bus.x[32*k +: 32];
      end
      if (bus.rst_user) begin
        sat_hi_q <= '0;
        sat_lo_q <= '0;
        y_q      <= '0;
        for (int k = 0; k < N_CH; k++) begin
          integ_q[k] <= 32'd0;
          xprev_q[k] <= 32'd0;
          ysh_q[k]   <= 32'd0;
        end
      end else begin
        if (wb_vld) begin
          integ_q[wb_sb.ch]  <= ci_q[ADD_LAT+1];
          xprev_q[wb_sb.ch]  <= wb_sb.x;
          ysh_q[wb_sb.ch]    <= y6_q;
          sat_hi_q[wb_sb.ch] <= hi6_q;
          sat_lo_q[wb_sb.ch] <= lo6_q;
        end
        if (state_q == DRAIN && state_d == DONE)
          y_q <= ypack_d;
      end
    end
  end

  assign bus.y        = y_q;
  assign bus.done_sig = (state_q == DONE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_pi_limit_multich.sv
// Directed bench for pi_limit_multich: one MODE=0 and one MODE=1 instance share clock and reset.
module tb_pi_limit_multich;

  localparam logic [31:0] F1    = 32'h3F800000;
  localparam logic [31:0] FM1   = 32'hBF800000;
  localparam logic [31:0] F075  = 32'h3F400000;
  localparam logic [31:0] FM075 = 32'hBF400000;
  localparam logic [31:0] F125  = 32'h3FA00000;
  localparam logic [31:0] F15   = 32'h3FC00000;
  localparam logic [31:0] FM15  = 32'hBFC00000;
  localparam logic [31:0] FM4   = 32'hC0800000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   lat;
  int   cyc;
  int   ndone;
  int   first_done;

  pi_limit_multich_if #(.N_CH(4)) if0();
  pi_limit_multich_if #(.N_CH(4)) if1();

  pi_limit_multich #(.N_CH(4), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  pi_limit_multich #(.N_CH(4), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse sta on both instances, scramble x afterwards, and wait (bounded) for done on dut0.
  task automatic step(input logic [127:0] xa, input logic [127:0] xb, output int n);
    @(negedge clk);
    if0.x   = xa;
    if1.x   = xb;
    if0.sta = 1'b1;
    if1.sta = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if0.sta = 1'b0;
        if1.sta = 1'b0;
        if0.x   = {$urandom, $urandom, $urandom, $urandom};
        if1.x   = {$urandom, $urandom, $urandom, $urandom};
      end
    end while (!if0.done_sig && n < 100);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    if0.rst_user = 1'b0;
    if1.rst_user = 1'b0;
    if0.sta      = 1'b0;
    if1.sta      = 1'b0;
    if0.x        = '0;
    if1.x        = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    chk("reset_y",       if0.y, 128'd0);
    chk("reset_done",    128'(if0.done_sig), 128'd0);
    chk("reset_busy",    128'(if0.busy), 128'd0);
    chk("reset_overrun", 128'(if0.overrun), 128'd0);

    // x0 = 1.0 on every step; MODE=0 integrator saturates, MODE=1 holds at 1.25
    step({96'd0, F1}, {96'd0, F1}, lat);
    chk("latency",   128'(lat), 128'd33);
    chk("done_m1",   128'(if1.done_sig), 128'd1);
    chk("s1_y_m0",   if0.y, {96'd0, F075});
    chk("s1_y_m1",   if1.y, {96'd0, F075});
    step({96'd0, F1}, {96'd0, F1}, lat);
    chk("s2_y_m0",   if0.y, {96'd0, F125});
    chk("s2_y_m1",   if1.y, {96'd0, F125});
    step({96'd0, F1}, {96'd0, F1}, lat);
    chk("s3_y_m0",   if0.y, {96'd0, F15});
    chk("s3_y_m1",   if1.y, {96'd0, F15});
    step({96'd0, F1}, {96'd0, F1}, lat);
    chk("s4_y_m0",   if0.y, {96'd0, F15});
    chk("s4_y_m1",   if1.y, {96'd0, F15});
    // x0 = -1.0: y = integ - 0.5 exposes integ (1.5 for MODE=0, 1.25 for MODE=1)
    step({96'd0, FM1}, {96'd0, FM1}, lat);
    chk("s5_y_m0",   if0.y, {96'd0, F1});
    chk("s5_y_m1",   if1.y, {96'd0, F075});

    @(negedge clk);
    if0.rst_user = 1'b1;
    if1.rst_user = 1'b1;
    @(negedge clk);
    if0.rst_user = 1'b0;
    if1.rst_user = 1'b0;
    chk("rstu_y_m0", if0.y, 128'd0);
    chk("rstu_y_m1", if1.y, 128'd0);

    // Independent channels from a clean state
    step({FM4, 32'd0, FM1, F1}, 128'd0, lat);
    chk("mix_y",     if0.y, {FM15, 32'd0, FM075, F075});
    chk("mix_lat",   128'(lat), 128'd33);

    @(negedge clk);
    if0.rst_user = 1'b1;
    @(negedge clk);
    if0.rst_user = 1'b0;

    // Second sta 10 cycles in is ignored and flagged
    @(negedge clk);
    if0.x   = {96'd0, F1};
    if0.sta = 1'b1;
    cyc = 0; ndone = 0; first_done = 0;
    repeat (60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if0.sta = 1'b0;
        if0.x   = {$urandom, $urandom, $urandom, $urandom};
        chk("ovr_busy",  128'(if0.busy), 128'd1);
      end
      if (cyc == 10) begin
        if0.sta = 1'b1;
        if0.x   = {FM4, FM4, FM4, FM4};
      end
      if (cyc == 11) begin
        chk("ovr_pulse", 128'(if0.overrun), 128'd1);
        if0.sta = 1'b0;
      end
      if (cyc == 12) chk("ovr_clear", 128'(if0.overrun), 128'd0);
      if (if0.done_sig) begin
        ndone++;
        first_done = cyc;
      end
    end
    chk("ovr_ndone",  128'(ndone), 128'd1);
    chk("ovr_doncyc", 128'(first_done), 128'd33);
    chk("ovr_y",      if0.y, {96'd0, F075});
    chk("ovr_idle",   128'(if0.busy), 128'd0);

    // rst_user 15 cycles into a step aborts it and clears state
    @(negedge clk);
    if0.x   = {96'd0, F1};
    if0.sta = 1'b1;
    cyc = 0; ndone = 0;
    repeat (45) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) if0.sta = 1'b0;
      if (cyc == 15) if0.rst_user = 1'b1;
      if (cyc == 16) begin
        if0.rst_user = 1'b0;
        chk("abort_y",    if0.y, 128'd0);
        chk("abort_busy", 128'(if0.busy), 128'd0);
      end
      if (if0.done_sig) ndone++;
    end
    chk("abort_ndone", 128'(ndone), 128'd0);
    step({96'd0, F1}, 128'd0, lat);
    chk("abort_next_y", if0.y, {96'd0, F075});

    // Asynchronous reset mid-step clears outputs without waiting for a clock edge
    @(negedge clk);
    if0.x   = {96'd0, F1};
    if0.sta = 1'b1;
    @(negedge clk);
    if0.sta = 1'b0;
    repeat (19) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_y",    if0.y, 128'd0);
    chk("arst_busy", 128'(if0.busy), 128'd0);
    chk("arst_done", 128'(if0.done_sig), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    step({96'd0, F1}, 128'd0, lat);
    chk("arst_next_y", if0.y, {96'd0, F075});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
